rv32_bus_arbiter: RTL and testbench
===================================

RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits (range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr_request  input  memory_request_t  fetch-side request (op, addr[31:0], data[31:0]); MEM_NOP = no request.
REQ-005 instr_cancel  input  1  fetch flush (jump taken); drops the in-flight instruction request.
REQ-006 instr_done  output  1  one-cycle pulse: instruction access complete.
REQ-007 instr_rdata  output  32  read data for instr_done.
REQ-008 data_request  input  memory_request_t  memory-stage request (loads and stores); MEM_NOP = no request.
REQ-009 data_done  output  1  one-cycle pulse: data access complete.
REQ-010 data_rdata  output  32  read data for data_done.
REQ-011 bus_request  output  memory_request_t  request to the shared memory bus.
REQ-012 bus_ready  input  1  one-cycle pulse from the bus: current access complete.
REQ-013 bus_rdata  input  32  bus read data, valid with bus_ready.

Function
REQ-014 The arbiter SHALL implement three states: IDLE, BUSY_I, BUSY_D.
REQ-015 A requester SHALL hold its request stable until its done pulse; a request is pending when op != MEM_NOP.
REQ-016 In IDLE with only one request pending, the arbiter SHALL enter the matching BUSY state on the next edge.
REQ-017 In IDLE with both pending, data SHALL win unless starve_cnt == STARVE_LIMIT, in which case instruction wins.
REQ-018 On entering a BUSY state, the winner's request SHALL be latched into a register and bus_request SHALL be driven only from that register.
REQ-019 In IDLE, bus_request.op SHALL be MEM_NOP, addr and data 0.
REQ-020 In BUSY_x with bus_ready = 1, the owner's done SHALL pulse in the same cycle, its rdata SHALL equal bus_rdata, and the state SHALL return to IDLE on the next edge.
REQ-021 At least one IDLE cycle SHALL separate consecutive bus accesses; minimum request-to-done latency is 1 cycle after grant.
REQ-022 The non-owner's done SHALL remain 0; both rdata outputs SHALL be 0 when their done is 0.
REQ-023 starve_cnt (4 bits) SHALL increment on each data grant made while an instruction request is pending, saturate at STARVE_LIMIT, and clear on any instruction grant or in IDLE with no instruction request pending.
REQ-024 instr_cancel in BUSY_I SHALL set a cancelled flag; the bus access SHALL still complete, but instr_done SHALL be suppressed at bus_ready. The flag SHALL clear on exit to IDLE.
REQ-025 instr_cancel in the same cycle as bus_ready in BUSY_I SHALL also suppress instr_done.
REQ-026 instr_cancel in IDLE or BUSY_D SHALL have no effect on state.
REQ-027 A request withdrawn to MEM_NOP before being granted SHALL never be granted.
REQ-028 bus_ready in IDLE SHALL be ignored, with no done pulse.
REQ-029 Store ops SHALL be forwarded unchanged; the arbiter SHALL not interpret op beyond the MEM_NOP test.

Reset
REQ-030 While reset = 1, asynchronously: state IDLE, latched request cleared, bus_request.op = MEM_NOP, starve_cnt 0, cancelled flag 0, instr_done = data_done = 0.
REQ-031 A reset asserted mid-access SHALL abandon the access; a bus_ready arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-032 Instr LW addr 0x100, bus_ready 2 cycles after grant with rdata 0xDEADBEEF -> bus_request.addr = 0x100 from the cycle after the request; instr_done pulses once with instr_rdata 0xDEADBEEF; data_done stays 0.
REQ-033 Both requests held continuously, bus_ready 1 cycle after every grant, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 instr_cancel during BUSY_I, bus_ready 3 cycles later -> no instr_done pulse; IDLE follows; pending data request granted next.
REQ-035 Data SW addr 0x2000, data 0x55 -> bus_request carries op SW, addr 0x2000, data 0x55 unchanged; data_done pulses.
REQ-036 Reset asserted in BUSY_D, released, then a stray bus_ready -> bus_request.op = MEM_NOP immediately with no clock edge required; no done pulses.
REQ-037 bus_ready pulsed in IDLE with no requests -> no state change, no done pulses.

Source files
------------

// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: shares one memory bus between the fetch and memory stages.
// Data normally wins ties; a saturating starvation counter forces an
// instruction grant after STARVE_LIMIT back-to-back data grants.

package rv32_bus_arbiter_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_request_t;

endpackage

module rv32_bus_arbiter
  import rv32_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  memory_request_t instr_request,
  input  logic            instr_cancel,
  output logic            instr_done,
  output logic [31:0]     instr_rdata,
  input  memory_request_t data_request,
  output logic            data_done,
  output logic [31:0]     data_rdata,
  output memory_request_t bus_request,
  input  logic            bus_ready,
  input  logic [31:0]     bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t          state;
  memory_request_t req_q;
  logic [3:0]      starve_cnt;
  logic            cancelled;

  logic instr_pending;
  logic data_pending;
  logic grant_i;
  logic grant_d;

  assign instr_pending = (instr_request.op != MEM_NOP);
  assign data_pending  = (data_request.op  != MEM_NOP);

  // Grant decision: only made in IDLE; data wins unless instruction is starved.
  assign grant_i = (state == IDLE) && instr_pending &&
                   (!data_pending || (starve_cnt == LIMIT));
  assign grant_d = (state == IDLE) && data_pending && !grant_i;

  // Arbitration FSM; also owns the latched bus request, counter and cancel flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      starve_cnt <= 4'd0;
      cancelled  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cancelled <= 1'b0;
          if (grant_i) begin
            state      <= BUSY_I;
            req_q      <= instr_request;
            starve_cnt <= 4'd0;
          end else if (grant_d) begin
            state <= BUSY_D;
            req_q <= data_request;
            if (!instr_pending) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt < LIMIT) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (!instr_pending) begin
            starve_cnt <= 4'd0;
          end
        end
        BUSY_I: begin
          if (instr_cancel) begin
            cancelled <= 1'b1;
          end
          if (bus_ready) begin
            state     <= IDLE;
            req_q     <= '0;
            cancelled <= 1'b0;
          end
        end
        BUSY_D: begin
          if (bus_ready) begin
            state <= IDLE;
            req_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= '0;
        end
      endcase
    end
  end

  // The bus only ever sees the latched request; it is cleared whenever IDLE.
  assign bus_request = req_q;

  // Completion pulses: same cycle as bus_ready, gated by owner and cancel state.
  // NOTE: every output is fully assigned on every path, so no latch is inferred.
  always_comb begin
    instr_done  = (state == BUSY_I) && bus_ready && !cancelled && !instr_cancel;
    data_done   = (state == BUSY_D) && bus_ready;
    instr_rdata = instr_done ? bus_rdata : 32'd0;
    data_rdata  = data_done  ? bus_rdata : 32'd0;
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed self-checking bench for rv32_bus_arbiter.
module tb_rv32_bus_arbiter;
  import rv32_bus_arbiter_pkg::*;

  logic            clk;
  logic            reset;
  memory_request_t instr_request;
  logic            instr_cancel;
  logic            instr_done;
  logic [31:0]     instr_rdata;
  memory_request_t data_request;
  logic            data_done;
  logic [31:0]     data_rdata;
  memory_request_t bus_request;
  logic            bus_ready;
  logic [31:0]     bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_request (instr_request),
    .instr_cancel  (instr_cancel),
    .instr_done    (instr_done),
    .instr_rdata   (instr_rdata),
    .data_request  (data_request),
    .data_done     (data_done),
    .data_rdata    (data_rdata),
    .bus_request   (bus_request),
    .bus_ready     (bus_ready),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic memory_request_t mk_req(input mem_op_t op, input logic [31:0] addr,
                                             input logic [31:0] data);
    memory_request_t r;
    r.op   = op;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_quiet(input string tag);
    check({tag, "_op"},     64'(bus_request.op), 64'(MEM_NOP));
    check({tag, "_idone"},  64'(instr_done), 64'd0);
    check({tag, "_ddone"},  64'(data_done), 64'd0);
  endtask

  initial begin
    logic exp_i;
    reset         = 1'b1;
    instr_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    data_request  = mk_req(MEM_NOP, 32'd0, 32'd0);
    instr_cancel  = 1'b0;
    bus_ready     = 1'b0;
    bus_rdata     = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_quiet("reset");
    check("reset_addr",   64'(bus_request.addr), 64'd0);
    check("reset_irdata", 64'(instr_rdata), 64'd0);
    check("reset_drdata", 64'(data_rdata), 64'd0);
    reset = 1'b0;

    // Stray bus_ready in IDLE with no requests
    tick();
    bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
    #1;
    check_idle_quiet("idle_ready");
    tick();
    bus_ready = 1'b0;
    #1;
    check_idle_quiet("idle_ready_after");

    // Instruction LW 0x100, bus_ready two cycles after grant
    instr_request = mk_req(MEM_LW, 32'h100, 32'd0);
    #1;
    check("i_req_cycle_op", 64'(bus_request.op), 64'(MEM_NOP));
    tick();
    check("i_grant_addr", 64'(bus_request.addr), 64'h100);
    check("i_grant_op",   64'(bus_request.op), 64'(MEM_LW));
    check("i_wait1_done", 64'(instr_done), 64'd0);
    tick();
    check("i_wait2_addr", 64'(bus_request.addr), 64'h100);
    check("i_wait2_done", 64'(instr_done), 64'd0);
    tick();
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    check("i_done",        64'(instr_done), 64'd1);
    check("i_rdata",       64'(instr_rdata), 64'hDEAD_BEEF);
    check("i_ddone_quiet", 64'(data_done), 64'd0);
    check("i_drdata_zero", 64'(data_rdata), 64'd0);
    tick();
    bus_ready = 1'b0; instr_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    #1;
    check_idle_quiet("i_after");

    // Starvation: both held, bus_ready one cycle after every grant
    instr_request = mk_req(MEM_LW, 32'h400, 32'd0);
    data_request  = mk_req(MEM_LW, 32'h800, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_i = (k == 4) || (k == 9);
      check($sformatf("starve_grant%0d", k), 64'(bus_request.addr),
            exp_i ? 64'h400 : 64'h800);
      bus_ready = 1'b1; bus_rdata = 32'h1000 + 32'(k);
      #1;
      check($sformatf("starve_idone%0d", k), 64'(instr_done), 64'(exp_i));
      check($sformatf("starve_ddone%0d", k), 64'(data_done), 64'(!exp_i));
      tick();
      bus_ready = 1'b0;
      #1;
      check($sformatf("starve_gap%0d", k), 64'(bus_request.op), 64'(MEM_NOP));
    end
    instr_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    data_request  = mk_req(MEM_NOP, 32'd0, 32'd0);
    tick();

    // Cancel during BUSY_I, bus_ready three cycles later, data pending
    instr_request = mk_req(MEM_LW, 32'h104, 32'd0);
    tick();
    check("c_grant_addr", 64'(bus_request.addr), 64'h104);
    instr_cancel  = 1'b1;
    instr_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    data_request  = mk_req(MEM_LW, 32'h900, 32'd0);
    #1;
    check("c_cancel_done", 64'(instr_done), 64'd0);
    tick();
    instr_cancel = 1'b0;
    tick();
    check("c_still_busy", 64'(bus_request.addr), 64'h104);
    tick();
    bus_ready = 1'b1; bus_rdata = 32'h0000_CAFE;
    #1;
    check("c_idone_suppressed", 64'(instr_done), 64'd0);
    check("c_irdata_zero",      64'(instr_rdata), 64'd0);
    check("c_ddone_quiet",      64'(data_done), 64'd0);
    tick();
    bus_ready = 1'b0;
    #1;
    check("c_idle_op", 64'(bus_request.op), 64'(MEM_NOP));
    tick();
    check("c_data_grant", 64'(bus_request.addr), 64'h900);
    bus_ready = 1'b1; bus_rdata = 32'h0000_0042;
    #1;
    check("c_data_done",  64'(data_done), 64'd1);
    check("c_data_rdata", 64'(data_rdata), 64'h42);
    tick();
    bus_ready = 1'b0; data_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    tick();

    // Cancel coincident with bus_ready
    instr_request = mk_req(MEM_LW, 32'h108, 32'd0);
    tick();
    bus_ready = 1'b1; instr_cancel = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    instr_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    #1;
    check("cr_idone", 64'(instr_done), 64'd0);
    tick();
    bus_ready = 1'b0; instr_cancel = 1'b0;
    #1;
    check_idle_quiet("cr_after");

    // Store forwarded unchanged
    data_request = mk_req(MEM_SW, 32'h2000, 32'h55);
    tick();
    check("sw_op",   64'(bus_request.op), 64'(MEM_SW));
    check("sw_addr", 64'(bus_request.addr), 64'h2000);
    check("sw_data", 64'(bus_request.data), 64'h55);
    bus_ready = 1'b1; bus_rdata = 32'h1234;
    #1;
    check("sw_ddone", 64'(data_done), 64'd1);
    check("sw_idone", 64'(instr_done), 64'd0);
    tick();
    bus_ready = 1'b0; data_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    tick();

    // Instruction request withdrawn before grant is never granted
    data_request = mk_req(MEM_LW, 32'h500, 32'd0);
    tick();
    instr_request = mk_req(MEM_LW, 32'h600, 32'd0);
    tick();
    instr_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    bus_ready = 1'b1;
    #1;
    check("wd_ddone", 64'(data_done), 64'd1);
    tick();
    bus_ready = 1'b0; data_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    tick();
    check("wd_no_grant1", 64'(bus_request.op), 64'(MEM_NOP));
    tick();
    check("wd_no_grant2", 64'(bus_request.op), 64'(MEM_NOP));

    // Asynchronous reset mid-access, then stray bus_ready
    data_request = mk_req(MEM_LW, 32'h3000, 32'd0);
    tick();
    check("rst_busy_op", 64'(bus_request.op), 64'(MEM_LW));
    #1;
    reset = 1'b1; bus_ready = 1'b1;
    #1;
    check("rst_async_op",   64'(bus_request.op), 64'(MEM_NOP));
    check("rst_async_addr", 64'(bus_request.addr), 64'd0);
    check("rst_async_done", 64'(data_done), 64'd0);
    reset = 1'b0; data_request = mk_req(MEM_NOP, 32'd0, 32'd0);
    #1;
    check_idle_quiet("rst_stray");
    tick();
    bus_ready = 1'b0;
    #1;
    check_idle_quiet("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
